// File: rtl/elevador_fsm_3pisos_if.sv
// Bundle of the elevator core's call inputs and its display, motor and door outputs.
interface elevador_fsm_3pisos_if;
  logic [2:0] call;
  logic       floor_i0;
  logic       floor_i1;
  logic       blink_en;
  logic       blink_clk;
  logic       motor_up;
  logic       motor_down;
  logic       door_open;
  logic [2:0] pending;

  modport master (
    output call,
    input  floor_i0, floor_i1, blink_en, blink_clk,
    input  motor_up, motor_down, door_open, pending
  );

  modport slave (
    input  call,
    output floor_i0, floor_i1, blink_en, blink_clk,
    output motor_up, motor_down, door_open, pending
  );
endinterface

// File: rtl/elevador_fsm_3pisos.sv
// Three-floor elevator control core: latches calls, sequences travel and door
// dwell, tracks the floor and drives the blinking floor display.
module elevador_fsm_3pisos #(
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000,
  parameter int BLINK_HALF    = 12_500_000
) (
  input logic                  clock,
  input logic                  reset,
  elevador_fsm_3pisos_if.slave bus
);
  localparam int TW = $clog2(TRAVEL_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES);
  // A half-period of one cycle still needs a one-bit counter.
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  state_t        state, state_n;
  logic [1:0]    floor, floor_n;
  logic [2:0]    pend, pend_n, clr;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          blink, blink_n;
  logic          last_up, last_up_n;
  logic          moving, moving_n;
  logic          mup, mdn, dopen, ben;

  // Call-bit position of a floor code (floor1 -> bit0).
  function automatic logic [2:0] onehot(input logic [1:0] f);
    case (f)
      2'd1:    onehot = 3'b001;
      2'd2:    onehot = 3'b010;
      2'd3:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  function automatic logic above(input logic [2:0] p, input logic [1:0] f);
    case (f)
      2'd1:    above = |p[2:1];
      2'd2:    above = p[2];
      default: above = 1'b0;
    endcase
  endfunction

  function automatic logic below(input logic [2:0] p, input logic [1:0] f);
    case (f)
      2'd3:    below = |p[1:0];
      2'd2:    below = p[0];
      default: below = 1'b0;
    endcase
  endfunction

  // Next-state, travel/door counters and the service mask for pending calls.
  always_comb begin
    state_n   = state;
    floor_n   = floor;
    tcnt_n    = '0;
    dcnt_n    = '0;
    last_up_n = last_up;
    clr       = 3'b000;
    case (state)
      IDLE: begin
        if (|(pend & onehot(floor))) begin
          clr     = onehot(floor);
          state_n = DOOR;
        end else if (above(pend, floor) && (last_up || !below(pend, floor))) begin
          state_n = MOVE_UP;
        end else if (below(pend, floor)) begin
          state_n = MOVE_DOWN;
        end
      end
      MOVE_UP: begin
        if (tcnt == TW'(TRAVEL_CYCLES - 1)) begin
          floor_n   = floor + 2'd1;
          last_up_n = 1'b1;
          if (|(pend & onehot(floor_n))) begin
            clr     = onehot(floor_n);
            state_n = DOOR;
          end else if (!above(pend, floor_n)) begin
            state_n = IDLE;
          end
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      MOVE_DOWN: begin
        if (tcnt == TW'(TRAVEL_CYCLES - 1)) begin
          floor_n   = floor - 2'd1;
          last_up_n = 1'b0;
          if (|(pend & onehot(floor_n))) begin
            clr     = onehot(floor_n);
            state_n = DOOR;
          end else if (!below(pend, floor_n)) begin
            state_n = IDLE;
          end
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      DOOR: begin
        // Any call for this floor while open is absorbed and re-arms the dwell.
        clr = onehot(floor);
        if (|(bus.call & onehot(floor))) begin
          dcnt_n = '0;
        end else if (dcnt == DW'(DOOR_CYCLES - 1)) begin
          state_n = IDLE;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    pend_n = (pend | bus.call) & ~clr;
  end

  // Blink wave: restarts high on motion entry, free-runs across floor passes.
  always_comb begin
    moving   = (state == MOVE_UP) || (state == MOVE_DOWN);
    moving_n = (state_n == MOVE_UP) || (state_n == MOVE_DOWN);
    blink_n  = 1'b1;
    bcnt_n   = '0;
    if (moving && moving_n) begin
      if (bcnt == BW'(BLINK_HALF - 1)) begin
        blink_n = ~blink;
      end else begin
        blink_n = blink;
        bcnt_n  = bcnt + BW'(1);
      end
    end
  end

  // Core state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      floor   <= 2'd1;
      pend    <= 3'b000;
      tcnt    <= '0;
      dcnt    <= '0;
      bcnt    <= '0;
      blink   <= 1'b1;
      last_up <= 1'b1;
    end else begin
      state   <= state_n;
      floor   <= floor_n;
      pend    <= pend_n;
      tcnt    <= tcnt_n;
      dcnt    <= dcnt_n;
      bcnt    <= bcnt_n;
      blink   <= blink_n;
      last_up <= last_up_n;
    end
  end

  // Drive outputs registered from the next state so they change with the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mup   <= 1'b0;
      mdn   <= 1'b0;
      dopen <= 1'b0;
      ben   <= 1'b0;
    end else begin
      mup   <= (state_n == MOVE_UP);
      mdn   <= (state_n == MOVE_DOWN);
      dopen <= (state_n == DOOR);
      ben   <= moving_n;
    end
  end

  assign bus.floor_i0   = floor[0];
  assign bus.floor_i1   = floor[1];
  assign bus.pending    = pend;
  assign bus.motor_up   = mup;
  assign bus.motor_down = mdn;
  assign bus.door_open  = dopen;
  assign bus.blink_en   = ben;
  assign bus.blink_clk  = blink;
endmodule

// File: doc/elevador_fsm_3pisos.md
Name: elevador_fsm_3pisos

Overview:
- Control core for the 3-floor elevator.
- Latches floor calls, sequences motor travel and door dwell, and tracks the current floor.
- Drives the downstream 7-segment display controller through three signals:
  - `floor_i0` / `floor_i1`: binary floor code, with floor1 = 01, floor2 = 10, floor3 = 11.
  - `blink_en`: intermittent-display request, asserted while travelling.
  - `blink_clk`: the blink square wave.

Parameters:
- `TRAVEL_CYCLES`, 50_000_000, clock cycles to travel one floor (≥2).
- `DOOR_CYCLES`, 100_000_000, clock cycles the door stays open (≥2).
- `BLINK_HALF`, 12_500_000, clock cycles per half-period of `blink_clk` (≥1).

Ports:
- `clock` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `call` input 3: floor call buttons; bit0 = floor1, bit1 = floor2, bit2 = floor3. Level or pulse, sampled every edge.
- `floor_i0` output 1: LSB of the current floor code.
- `floor_i1` output 1: MSB of the current floor code.
- `blink_en` output 1: high while the car is moving; feeds display `ip`.
- `blink_clk` output 1: blink square wave; feeds the display clock input.
- `motor_up` output 1: drive car upward.
- `motor_down` output 1: drive car downward.
- `door_open` output 1: door open command.
- `pending` output 3: latched outstanding calls, same bit mapping as `call`.

Behaviour:
- One clock. `reset` is asynchronous and active-high. All registers are rising-edge.
- Reset values:
  - floor = 1 (`floor_i1`=0, `floor_i0`=1)
  - state = IDLE, `pending` = 000
  - `motor_up` = `motor_down` = `door_open` = 0
  - `blink_en` = 0, `blink_clk` = 1
  - all counters = 0, last_dir = UP
- Reset asserted mid-operation returns to these values immediately, with no motor/door glitch beyond reset release.
- Call latching:
  - `pending[n]` is set on the edge after `call[n]`=1.
  - It is cleared only by service: entry to, or dwell in, DOOR at floor n.
  - A set and a clear on the same bit in the same cycle resolve to clear when the car is in DOOR at that floor.
- State IDLE (all drive outputs 0):
  - If `pending[floor]` → clear it, go to DOOR.
  - Else if any pending above and (last_dir=UP or none below) → MOVE_UP.
  - Else if any pending below → MOVE_DOWN.
  - Else stay.
  - Decision is one cycle after `pending` updates.
- State MOVE_UP (`motor_up`=1, `blink_en`=1):
  - travel counter counts 0..TRAVEL_CYCLES-1.
  - At terminal count: floor +1, counter ← 0, last_dir ← UP.
  - If `pending[new floor]` → clear it, go to DOOR.
  - Else if pending still above → stay in MOVE_UP.
  - Else → IDLE.
  - Floor never exceeds 3; at floor 3, MOVE_UP is unreachable.
- State MOVE_DOWN: mirror of MOVE_UP (`motor_down`=1, floor −1, last_dir ← DOWN). Floor never below 1.
- State DOOR (`door_open`=1):
  - door counter counts 0..DOOR_CYCLES-1, then → IDLE.
  - A new call for the current floor during DOOR is cleared on the next edge and restarts the door counter at 0.
- `motor_up` and `motor_down` are never both 1. The motor is never on while `door_open`=1.
- Blink generator:
  - On entry to MOVE_UP/MOVE_DOWN: `blink_clk` ← 1, blink counter ← 0.
  - While moving, `blink_clk` toggles every BLINK_HALF cycles.
  - Outside motion, `blink_clk` is held at 1 and `blink_en` at 0, so the display is steady.
- `blink_clk` remains continuous across a mid-travel floor increment; it is not reset when the car passes a floor.
- All outputs are registered; no combinational path from `call` to any output.
- Counter widths are `$clog2` of the respective parameter. The floor register is 2 bits; value 00 is never produced.

Test Plan (parameters: TRAVEL_CYCLES=4, DOOR_CYCLES=3, BLINK_HALF=2):
- Reset release with no calls → floor code 01, `pending`=000, all drives 0, `blink_clk`=1, stable for 20 cycles.
- `call`=100 one-cycle pulse at floor1 → `pending`=100 next edge, `motor_up`=1 the edge after. After 4 cycles the code is 10, after 8 cycles it is 11. Then `door_open`=1 for 3 cycles, `pending`=000. `blink_en`=1 only during travel; `blink_clk` toggles every 2 cycles starting high.
- At floor3 idle, `call`=011 simultaneously → `motor_down`, stop at floor2 (door 3 cycles, `pending`=001), then continue down to floor1 and open the door. `pending` = 000 at end.
- `call`=001 held during DOOR at floor1 → door counter restarts each cycle, `door_open` stays 1 until the call drops, then 3 more cycles.
- While at floor2 with last_dir=UP and `call`=101 together → services floor3 first, then floor1. Motor outputs are never simultaneously 1.
- Assert `reset` mid-MOVE_UP between floors → outputs return to reset values asynchronously, before the next clock edge. Floor code is 01 and `pending`=000 after release.
